// File: rtl/hazard_stall_ctl_if.sv
// Pipeline-control bundle between the decode-side hazard controller and the core.
// Master drives instruction/handshake inputs; slave (the controller) drives pipeline controls.
interface hazard_stall_ctl_if;
  logic [31:0] instruction_fd;
  logic [31:0] instruction_de;
  logic        mem_read_de;
  logic        branch_taken_de;
  logic        mem_req_em;
  logic        mem_ack;
  logic        pc_write;
  logic        fd_write;
  logic        fd_flush;
  logic        stall_ctl;
  logic        freeze;
  logic        mem_timeout;
  logic [15:0] loaduse_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] memwait_cnt;

  modport master (
    output instruction_fd, instruction_de, mem_read_de, branch_taken_de, mem_req_em, mem_ack,
    input  pc_write, fd_write, fd_flush, stall_ctl, freeze, mem_timeout,
    input  loaduse_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  instruction_fd, instruction_de, mem_read_de, branch_taken_de, mem_req_em, mem_ack,
    output pc_write, fd_write, fd_flush, stall_ctl, freeze, mem_timeout,
    output loaduse_cnt, flush_cnt, memwait_cnt
  );
endinterface

// File: rtl/hazard_stall_ctl.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use bubbles, multi-cycle branch flush, memory-wait freeze.
// Optional event counters are built only when HAZARD_STALL_STATS_EN is defined.
module hazard_stall_ctl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input logic               clock,
  input logic               reset,
  hazard_stall_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LIM  = 8'(MEM_TIMEOUT);

  state_t     r_state;
  logic [2:0] r_fcnt;
  logic [7:0] r_wcnt;
  logic       r_timeout;

  logic [5:0] w_op_fd;
  logic [4:0] w_rs_fd;
  logic [4:0] w_rt_fd;
  logic [4:0] w_rt_de;
  logic       w_uses_rt;
  logic       w_hazard;
  logic       w_mem_stall;
  logic       w_do_freeze;
  logic       w_do_flush;
  logic       w_do_loaduse;
  logic       w_flush_cont;
  logic [7:0] w_wcnt_nxt;
  logic       w_unused_bits;

  assign w_op_fd     = bus.instruction_fd[31:26];
  assign w_rs_fd     = bus.instruction_fd[25:21];
  assign w_rt_fd     = bus.instruction_fd[20:16];
  assign w_rt_de     = bus.instruction_de[20:16];
  assign w_mem_stall = bus.mem_req_em & ~bus.mem_ack;
  assign w_unused_bits = ^{bus.instruction_fd[15:0], bus.instruction_de[31:21], bus.instruction_de[15:0]};

  // R-type, beq, bne and sw read rt as a source register
  always_comb begin
    case (w_op_fd)
      6'h00, 6'h04, 6'h05, 6'h2B: w_uses_rt = 1'b1;
      default:                    w_uses_rt = 1'b0;
    endcase
  end

  assign w_hazard = bus.mem_read_de && (w_rt_de != 5'd0) &&
                    ((w_rt_de == w_rs_fd) || (w_uses_rt && (w_rt_de == w_rt_fd)));

  // Classify the cycle: memory wait beats branch flush beats load-use
  always_comb begin
    w_do_freeze  = 1'b0;
    w_do_flush   = 1'b0;
    w_do_loaduse = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_do_freeze = 1'b1;
        end else if (bus.branch_taken_de) begin
          w_do_flush = 1'b1;
        end else begin
          w_do_loaduse = w_hazard;
        end
      end
      ST_FLUSH: begin
        if (w_mem_stall) begin
          w_do_freeze = 1'b1;
        end else begin
          w_do_flush = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (!bus.mem_ack) begin
          w_do_freeze = 1'b1;
        end else if ((r_fcnt != 3'd0) || bus.branch_taken_de) begin
          w_do_flush = 1'b1;
        end else begin
          w_do_loaduse = w_hazard;
        end
      end
      default: begin
        w_do_freeze  = 1'b0;
        w_do_flush   = 1'b0;
        w_do_loaduse = 1'b0;
      end
    endcase
  end

  // An interrupted flush resumes from its held count instead of restarting
  assign w_flush_cont = (r_state == ST_FLUSH) || ((r_state == ST_MEMWAIT) && (r_fcnt != 3'd0));

  // Wait count after this cycle: first frozen cycle loads 1, later ones saturate at 255
  always_comb begin
    if (r_state == ST_MEMWAIT) begin
      w_wcnt_nxt = (r_wcnt == 8'hFF) ? r_wcnt : (r_wcnt + 8'd1);
    end else begin
      w_wcnt_nxt = 8'd1;
    end
  end

  // Pipeline control outputs, forced to the bubble/flush pattern while in reset
  always_comb begin
    if (reset) begin
      bus.pc_write  = 1'b0;
      bus.fd_write  = 1'b0;
      bus.fd_flush  = 1'b1;
      bus.stall_ctl = 1'b1;
      bus.freeze    = 1'b0;
    end else if (w_do_freeze) begin
      bus.pc_write  = 1'b0;
      bus.fd_write  = 1'b0;
      bus.fd_flush  = 1'b0;
      bus.stall_ctl = 1'b0;
      bus.freeze    = 1'b1;
    end else if (w_do_flush) begin
      bus.pc_write  = 1'b1;
      bus.fd_write  = 1'b0;
      bus.fd_flush  = 1'b1;
      bus.stall_ctl = 1'b1;
      bus.freeze    = 1'b0;
    end else if (w_do_loaduse) begin
      bus.pc_write  = 1'b0;
      bus.fd_write  = 1'b0;
      bus.fd_flush  = 1'b0;
      bus.stall_ctl = 1'b1;
      bus.freeze    = 1'b0;
    end else begin
      bus.pc_write  = 1'b1;
      bus.fd_write  = 1'b1;
      bus.fd_flush  = 1'b0;
      bus.stall_ctl = 1'b0;
      bus.freeze    = 1'b0;
    end
  end

  // Sequencer state, flush/wait counters and sticky timeout flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_fcnt    <= 3'd0;
      r_wcnt    <= 8'd0;
      r_timeout <= 1'b0;
    end else if (w_do_freeze) begin
      r_state <= ST_MEMWAIT;
      r_wcnt  <= w_wcnt_nxt;
      if (w_wcnt_nxt >= TIMEOUT_LIM) begin
        r_timeout <= 1'b1;
      end
    end else if (w_do_flush) begin
      r_wcnt <= 8'd0;
      if (w_flush_cont) begin
        r_fcnt  <= (r_fcnt == 3'd0) ? 3'd0 : (r_fcnt - 3'd1);
        r_state <= (r_fcnt <= 3'd1) ? ST_RUN : ST_FLUSH;
      end else if (FLUSH_CYCLES > 1) begin
        r_fcnt  <= FLUSH_RELOAD;
        r_state <= ST_FLUSH;
      end else begin
        r_fcnt  <= 3'd0;
        r_state <= ST_RUN;
      end
    end else begin
      r_state <= ST_RUN;
      r_wcnt  <= 8'd0;
    end
  end

  assign bus.mem_timeout = r_timeout;

`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] r_loaduse_cnt;
  logic [15:0] r_flush_cnt;
  logic [15:0] r_memwait_cnt;

  // Saturating event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_loaduse_cnt <= 16'd0;
      r_flush_cnt   <= 16'd0;
      r_memwait_cnt <= 16'd0;
    end else begin
      if (w_do_loaduse && (r_loaduse_cnt != 16'hFFFF)) begin
        r_loaduse_cnt <= r_loaduse_cnt + 16'd1;
      end
      if (w_do_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
      if (w_do_freeze && (r_memwait_cnt != 16'hFFFF)) begin
        r_memwait_cnt <= r_memwait_cnt + 16'd1;
      end
    end
  end

  assign bus.loaduse_cnt = r_loaduse_cnt;
  assign bus.flush_cnt   = r_flush_cnt;
  assign bus.memwait_cnt = r_memwait_cnt;
`else
  assign bus.loaduse_cnt = 16'd0;
  assign bus.flush_cnt   = 16'd0;
  assign bus.memwait_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctl.sv
// Self-checking bench for hazard_stall_ctl (FLUSH_CYCLES=3, MEM_TIMEOUT=15).
module tb_hazard_stall_ctl;
  localparam int FC = 3;
  localparam int MT = 15;
  // {pc_write, fd_write, fd_flush, stall_ctl, freeze}
  localparam logic [4:0] O_DEF = 5'b11000;
  localparam logic [4:0] O_LU  = 5'b00010;
  localparam logic [4:0] O_BR  = 5'b10110;
  localparam logic [4:0] O_FZ  = 5'b00001;
  localparam logic [4:0] O_RST = 5'b00110;
`ifdef HAZARD_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [31:0] LW5    = 32'h8C050000; // lw $5,0($0)
  localparam logic [31:0] LW0    = 32'h8C000000; // lw $0,0($0)
  localparam logic [31:0] ADD_RS = 32'h00A13020; // add $6,$5,$1
  localparam logic [31:0] ADD_RT = 32'h00253020; // add $6,$1,$5
  localparam logic [31:0] ADD_Z  = 32'h00013020; // add $6,$0,$1

  logic clock = 1'b0;
  logic reset = 1'b1;

  hazard_stall_ctl_if bus();

  hazard_stall_ctl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] ifd;
    logic [31:0] ide;
    logic        mrd;
    logic        br;
    logic        mreq;
    logic        mack;
    logic [4:0]  eo;
    logic        eto;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[14];
  int checks = 0;
  int errors = 0;
  int m_lu = 0;
  int m_fl = 0;
  int m_mw = 0;

  function automatic vec_t mk(string nm, logic [31:0] ifd, logic [31:0] ide, logic mrd, logic br,
                              logic mreq, logic mack, logic [4:0] eo, logic eto);
    vec_t v;
    v.name = nm; v.ifd = ifd; v.ide = ide; v.mrd = mrd; v.br = br;
    v.mreq = mreq; v.mack = mack; v.eo = eo; v.eto = eto;
    return v;
  endfunction

  task automatic check_outs(string nm, logic [4:0] eo, logic eto);
    logic [4:0] ao;
    ao = {bus.pc_write, bus.fd_write, bus.fd_flush, bus.stall_ctl, bus.freeze};
    checks++;
    if (ao !== eo) begin
      errors++;
      $display("FAIL %s ctl: got %b expected %b (pc,fd,flush,stall,freeze)", nm, ao, eo);
    end
    checks++;
    if (bus.mem_timeout !== eto) begin
      errors++;
      $display("FAIL %s mem_timeout: got %b expected %b", nm, bus.mem_timeout, eto);
    end
  endtask

  task automatic check_cnt(string nm);
    logic [15:0] e_lu, e_fl, e_mw;
    e_lu = STATS ? 16'(m_lu) : 16'd0;
    e_fl = STATS ? 16'(m_fl) : 16'd0;
    e_mw = STATS ? 16'(m_mw) : 16'd0;
    checks++;
    if ({bus.loaduse_cnt, bus.flush_cnt, bus.memwait_cnt} !== {e_lu, e_fl, e_mw}) begin
      errors++;
      $display("FAIL %s counters: got lu=%0d fl=%0d mw=%0d expected lu=%0d fl=%0d mw=%0d", nm,
               bus.loaduse_cnt, bus.flush_cnt, bus.memwait_cnt, e_lu, e_fl, e_mw);
    end
  endtask

  // Drive one cycle, queue its expectation, compare at the falling edge.
  task automatic step(vec_t v);
    vec_t e;
    bus.instruction_fd  = v.ifd;
    bus.instruction_de  = v.ide;
    bus.mem_read_de     = v.mrd;
    bus.branch_taken_de = v.br;
    bus.mem_req_em      = v.mreq;
    bus.mem_ack         = v.mack;
    sb_q.push_back(v);
    if (v.eo == O_LU) m_lu++;
    if (v.eo[2])      m_fl++;
    if (v.eo[0])      m_mw++;
    @(negedge clock);
    e = sb_q.pop_front();
    check_outs(e.name, e.eo, e.eto);
    @(posedge clock);
    #1;
  endtask

  initial begin
    tbl[0]  = mk("idle",        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0);
    tbl[1]  = mk("lu_rs",       ADD_RS,       LW5,          1'b1, 1'b0, 1'b0, 1'b0, O_LU,  1'b0);
    tbl[2]  = mk("lu_bubble",   ADD_RS,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0);
    tbl[3]  = mk("lu_rt0",      ADD_Z,        LW0,          1'b1, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0);
    tbl[4]  = mk("lu_rt_rtype", ADD_RT,       LW5,          1'b1, 1'b0, 1'b0, 1'b0, O_LU,  1'b0);
    tbl[5]  = mk("addi_rt",     32'h20250004, LW5,          1'b1, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0);
    tbl[6]  = mk("sw_rt",       32'hAC250000, LW5,          1'b1, 1'b0, 1'b0, 1'b0, O_LU,  1'b0);
    tbl[7]  = mk("beq_rt",      32'h10250000, LW5,          1'b1, 1'b0, 1'b0, 1'b0, O_LU,  1'b0);
    tbl[8]  = mk("bne_rt",      32'h14250000, LW5,          1'b1, 1'b0, 1'b0, 1'b0, O_LU,  1'b0);
    tbl[9]  = mk("no_load",     ADD_RS,       LW5,          1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0);
    tbl[10] = mk("req_ack",     32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b1, O_DEF, 1'b0);
    tbl[11] = mk("req_ack_lu",  ADD_RS,       LW5,          1'b1, 1'b0, 1'b1, 1'b1, O_LU,  1'b0);
    tbl[12] = mk("lw_rt",       32'h8C250000, LW5,          1'b1, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0);
    tbl[13] = mk("lw_rs",       32'h8CA70000, LW5,          1'b1, 1'b0, 1'b0, 1'b0, O_LU,  1'b0);

    bus.instruction_fd = 32'h0; bus.instruction_de = 32'h0; bus.mem_read_de = 1'b0;
    bus.branch_taken_de = 1'b0; bus.mem_req_em = 1'b0; bus.mem_ack = 1'b0;
    #3;
    check_outs("reset", O_RST, 1'b0);
    check_cnt("reset");
    #4;
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 14; i++) step(tbl[i]);
    check_cnt("table");

    // Branch: exactly FC bubbles, pc_write held high
    step(mk("br_1", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR, 1'b0));
    for (int i = 0; i < FC - 1; i++) step(mk("br_n", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, O_BR, 1'b0));
    step(mk("br_done", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0));
    check_cnt("branch");

    // Branch with load-use hazard, branch held high during flush
    for (int i = 0; i < FC; i++) step(mk("br_prio", ADD_RS, LW5, 1'b1, 1'b1, 1'b0, 1'b0, O_BR, 1'b0));
    step(mk("br_prio_done", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0));
    check_cnt("br_prio");

    // Memory wait: 4 frozen cycles then ack
    for (int i = 0; i < 4; i++) step(mk("mw4", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, O_FZ, 1'b0));
    step(mk("mw4_ack", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, O_DEF, 1'b0));
    step(mk("mw4_after", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0));
    check_cnt("memwait4");

    // Memory wait on the 2nd flush cycle; flush resumes afterwards
    step(mk("fw_br", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR, 1'b0));
    step(mk("fw_fz1", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, O_FZ, 1'b0));
    step(mk("fw_fz2", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, O_FZ, 1'b0));
    step(mk("fw_ack", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, O_BR, 1'b0));
    step(mk("fw_last", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, O_BR, 1'b0));
    step(mk("fw_run", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0));
    check_cnt("flush_wait");

    // Long wait: timeout rises at the edge ending the 15th frozen cycle
    for (int i = 1; i <= 20; i++)
      step(mk("to_wait", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, O_FZ, (i > MT) ? 1'b1 : 1'b0));
    step(mk("to_ack", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, O_DEF, 1'b1));
    step(mk("to_sticky", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 1'b1));
    check_cnt("timeout");

    // Asynchronous reset in the middle of a wait
    step(mk("rw_fz1", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, O_FZ, 1'b1));
    step(mk("rw_fz2", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, O_FZ, 1'b1));
    #2;
    reset = 1'b1;
    #1;
    m_lu = 0; m_fl = 0; m_mw = 0;
    check_outs("async_rst", O_RST, 1'b0);
    check_cnt("async_rst");
    @(posedge clock);
    #1;
    check_outs("rst_hold", O_RST, 1'b0);
    #2;
    reset = 1'b0;
    step(mk("post_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 1'b0));
    step(mk("post_rst_lu", ADD_RS, LW5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, 1'b0));
    check_cnt("post_rst");

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
